// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Brief    : Instruction fetch stage. Owns the program counter, presents the
//            fetch address to a combinational instruction memory, and loads
//            the fetched word into the IF/ID pipeline register. Starts one
//            of ten resident programs, handles stall and branch redirect,
//            detects the halt (STA) word, drains the pipeline with bubbles
//            and pulses done.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter int          PC_W         = 16,
    parameter int          MEM_DEPTH    = 1024,
    parameter logic [15:0] NOP_INSTR    = 16'h6F0F,
    parameter logic [3:0]  HALT_OPCODE  = 4'b0001,
    parameter int          DRAIN_CYCLES = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [3:0]      prog_sel,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_target,
    input  logic [15:0]     M_instruction,
    output logic [PC_W-1:0] PCAdd_pc,
    output logic [15:0]     IF_ID_instruction,
    output logic [PC_W-1:0] IF_ID_pc,
    output logic            IF_ID_valid,
    output logic            busy,
    output logic            done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int                 c_cnt_w     = $clog2(DRAIN_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_init  = c_cnt_w'(DRAIN_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_zero  = '0;
    localparam logic [PC_W-1:0]    c_pc_one    = PC_W'(1);
    localparam logic [PC_W-1:0]    c_mem_depth = PC_W'(MEM_DEPTH);

    logic [1:0]         r_state;
    logic [PC_W-1:0]    r_pc;
    logic [15:0]        r_if_id_instr;
    logic [PC_W-1:0]    r_if_id_pc;
    logic               r_if_id_valid;
    logic [c_cnt_w-1:0] r_cnt;

    logic [1:0]         w_state_nxt;
    logic [PC_W-1:0]    w_pc_nxt;
    logic [15:0]        w_if_id_instr_nxt;
    logic [PC_W-1:0]    w_if_id_pc_nxt;
    logic               w_if_id_valid_nxt;
    logic [c_cnt_w-1:0] w_cnt_nxt;

    logic               w_sel_ok;
    logic [9:0]         w_prog_base;
    logic [PC_W-1:0]    w_start_pc;
    logic               w_is_halt;
    logic               w_pc_oor;

    // Program start address: prog_sel*100 in 10 bits, zero-extended to PC_W
    assign w_sel_ok    = (prog_sel >= 4'd1) && (prog_sel <= 4'd10);
    assign w_prog_base = {6'd0, prog_sel} * 10'd100;
    assign w_start_pc  = {{(PC_W-10){1'b0}}, w_prog_base};
    assign w_is_halt   = (M_instruction[15:12] == HALT_OPCODE);
    assign w_pc_oor    = (r_pc >= c_mem_depth);

    // Next-state and next-register values for the fetch controller
    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_if_id_instr_nxt = r_if_id_instr;
        w_if_id_pc_nxt    = r_if_id_pc;
        w_if_id_valid_nxt = r_if_id_valid;
        w_cnt_nxt         = r_cnt;

        case (r_state)
            S_IDLE: begin
                w_if_id_instr_nxt = NOP_INSTR;
                w_if_id_valid_nxt = 1'b0;
                if (start && w_sel_ok) begin
                    w_pc_nxt    = w_start_pc;
                    w_state_nxt = S_FETCH;
                end
            end

            S_FETCH: begin
                if (branch_taken) begin
                    // Redirect wins over stall: the wrong-path word is flushed
                    w_pc_nxt          = branch_target;
                    w_if_id_instr_nxt = NOP_INSTR;
                    w_if_id_valid_nxt = 1'b0;
                end else if (stall) begin
                    // Hold everything; decode re-reads the same IF/ID word
                end else if (w_pc_oor) begin
                    // Ran off the end of memory: treat like a halt, but the
                    // current word is not real so only bubbles go down
                    w_if_id_instr_nxt = NOP_INSTR;
                    w_if_id_valid_nxt = 1'b0;
                    w_cnt_nxt         = c_cnt_init;
                    w_state_nxt       = S_DRAIN;
                end else if (w_is_halt) begin
                    w_if_id_instr_nxt = M_instruction;
                    w_if_id_pc_nxt    = r_pc;
                    w_if_id_valid_nxt = 1'b1;
                    w_cnt_nxt         = c_cnt_init;
                    w_state_nxt       = S_DRAIN;
                end else begin
                    w_if_id_instr_nxt = M_instruction;
                    w_if_id_pc_nxt    = r_pc;
                    w_if_id_valid_nxt = 1'b1;
                    w_pc_nxt          = r_pc + c_pc_one;
                end
            end

            S_DRAIN: begin
                if (branch_taken) begin
                    // A branch older than the halt resolved late: resume fetch
                    w_pc_nxt          = branch_target;
                    w_if_id_instr_nxt = NOP_INSTR;
                    w_if_id_valid_nxt = 1'b0;
                    w_cnt_nxt         = c_cnt_zero;
                    w_state_nxt       = S_FETCH;
                end else if (!stall) begin
                    // Stall freezes both the counter and the IF/ID contents so
                    // the halt word is not overwritten before decode takes it
                    w_if_id_instr_nxt = NOP_INSTR;
                    w_if_id_valid_nxt = 1'b0;
                    if (r_cnt <= c_cnt_one) begin
                        w_cnt_nxt   = c_cnt_zero;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_cnt_nxt = r_cnt - c_cnt_one;
                    end
                end
            end

            S_DONE: begin
                w_if_id_instr_nxt = NOP_INSTR;
                w_if_id_valid_nxt = 1'b0;
                w_state_nxt       = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and pipeline registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_pc          <= '0;
            r_if_id_instr <= NOP_INSTR;
            r_if_id_pc    <= '0;
            r_if_id_valid <= 1'b0;
            r_cnt         <= c_cnt_zero;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_if_id_instr <= w_if_id_instr_nxt;
            r_if_id_pc    <= w_if_id_pc_nxt;
            r_if_id_valid <= w_if_id_valid_nxt;
            r_cnt         <= w_cnt_nxt;
        end
    end

    assign PCAdd_pc          = r_pc;
    assign IF_ID_instruction = r_if_id_instr;
    assign IF_ID_pc          = r_if_id_pc;
    assign IF_ID_valid       = r_if_id_valid;
    assign busy              = (r_state == S_FETCH) || (r_state == S_DRAIN);
    assign done              = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Brief    : Directed self-checking bench for fetch_stage with a behavioural
//            combinational instruction memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    localparam logic [15:0] c_nop = 16'h6F0F;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  prog_sel = 4'd0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [15:0] branch_target = 16'd0;
    logic [15:0] M_instruction;
    logic [15:0] PCAdd_pc;
    logic [15:0] IF_ID_instruction;
    logic [15:0] IF_ID_pc;
    logic        IF_ID_valid;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] tb_mem [0:2047];

    fetch_stage dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .prog_sel          (prog_sel),
        .stall             (stall),
        .branch_taken      (branch_taken),
        .branch_target     (branch_target),
        .M_instruction     (M_instruction),
        .PCAdd_pc          (PCAdd_pc),
        .IF_ID_instruction (IF_ID_instruction),
        .IF_ID_pc          (IF_ID_pc),
        .IF_ID_valid       (IF_ID_valid),
        .busy              (busy),
        .done              (done)
    );

    always #5 clk = ~clk;

    assign M_instruction = (PCAdd_pc < 16'd2048) ? tb_mem[PCAdd_pc[10:0]] : c_nop;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_checks++;
        if (PCAdd_pc !== 16'd0) begin n_fail++; $display("FAIL reset_pc: got %0d expected 0", PCAdd_pc); end
        n_checks++;
        if (IF_ID_instruction !== c_nop) begin n_fail++; $display("FAIL reset_instr: got %h expected %h", IF_ID_instruction, c_nop); end
        n_checks++;
        if ({IF_ID_pc, IF_ID_valid, busy, done} !== 19'd0) begin
            n_fail++; $display("FAIL reset_misc: got ifpc=%0d v=%b busy=%b done=%b expected all 0", IF_ID_pc, IF_ID_valid, busy, done);
        end
        reset = 1'b0;
        tick();
        n_checks++;
        if (busy !== 1'b0 || IF_ID_instruction !== c_nop) begin n_fail++; $display("FAIL idle_after_reset: got busy=%b instr=%h expected 0/%h", busy, IF_ID_instruction, c_nop); end
    endtask

    task automatic test_add_program();
        logic [15:0] exp_pc;
        start = 1'b1; prog_sel = 4'd1;
        tick();
        start = 1'b0;
        n_checks++;
        if (PCAdd_pc !== 16'd100 || busy !== 1'b1 || IF_ID_valid !== 1'b0) begin
            n_fail++; $display("FAIL add_start: got pc=%0d busy=%b v=%b expected 100/1/0", PCAdd_pc, busy, IF_ID_valid);
        end
        for (int i = 0; i < 8; i++) begin
            // A start while busy must be ignored
            if (i == 3) begin start = 1'b1; prog_sel = 4'd5; end
            tick();
            start = 1'b0;
            exp_pc = (i == 7) ? 16'd107 : 16'(101 + i);
            n_checks++;
            if (PCAdd_pc !== exp_pc) begin n_fail++; $display("FAIL add_pc[%0d]: got %0d expected %0d", i, PCAdd_pc, exp_pc); end
            n_checks++;
            if (IF_ID_pc !== 16'(100 + i) || IF_ID_instruction !== tb_mem[100 + i] || IF_ID_valid !== 1'b1) begin
                n_fail++; $display("FAIL add_ifid[%0d]: got pc=%0d instr=%h v=%b expected %0d/%h/1", i, IF_ID_pc, IF_ID_instruction, IF_ID_valid, 100 + i, tb_mem[100 + i]);
            end
        end
        n_checks++;
        if (IF_ID_instruction !== 16'h120F) begin n_fail++; $display("FAIL add_sta: got %h expected 120f", IF_ID_instruction); end
        for (int j = 1; j <= 4; j++) begin
            tick();
            n_checks++;
            if (done !== (j == 4) || busy !== (j != 4) || IF_ID_valid !== 1'b0 || IF_ID_instruction !== c_nop) begin
                n_fail++; $display("FAIL add_drain[%0d]: got done=%b busy=%b v=%b instr=%h expected %b/%b/0/%h", j, done, busy, IF_ID_valid, IF_ID_instruction, j == 4, j != 4, c_nop);
            end
        end
        tick();
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0 || PCAdd_pc !== 16'd107) begin
            n_fail++; $display("FAIL add_after_done: got done=%b busy=%b pc=%0d expected 0/0/107", done, busy, PCAdd_pc);
        end
    endtask

    task automatic test_stall();
        int dones;
        start = 1'b1; prog_sel = 4'd2;
        tick();
        start = 1'b0;
        tick();
        tick();
        n_checks++;
        if (PCAdd_pc !== 16'd202 || IF_ID_pc !== 16'd201) begin n_fail++; $display("FAIL stall_pre: got pc=%0d ifpc=%0d expected 202/201", PCAdd_pc, IF_ID_pc); end
        stall = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            n_checks++;
            if (PCAdd_pc !== 16'd202 || IF_ID_pc !== 16'd201 || IF_ID_instruction !== tb_mem[201] || IF_ID_valid !== 1'b1) begin
                n_fail++; $display("FAIL stall_hold[%0d]: got pc=%0d ifpc=%0d instr=%h v=%b expected 202/201/%h/1", k, PCAdd_pc, IF_ID_pc, IF_ID_instruction, IF_ID_valid, tb_mem[201]);
            end
        end
        stall = 1'b0;
        tick();
        n_checks++;
        if (PCAdd_pc !== 16'd203 || IF_ID_pc !== 16'd202 || IF_ID_instruction !== tb_mem[202]) begin
            n_fail++; $display("FAIL stall_resume: got pc=%0d ifpc=%0d instr=%h expected 203/202/%h", PCAdd_pc, IF_ID_pc, IF_ID_instruction, tb_mem[202]);
        end
        tick();
        n_checks++;
        if (IF_ID_pc !== 16'd203) begin n_fail++; $display("FAIL stall_next: got ifpc=%0d expected 203", IF_ID_pc); end
        dones = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (done === 1'b1) dones++;
        end
        n_checks++;
        if (dones != 1) begin n_fail++; $display("FAIL stall_done: got %0d done pulses expected 1", dones); end
    endtask

    task automatic test_branch();
        int dones;
        start = 1'b1; prog_sel = 4'd10;
        tick();
        start = 1'b0;
        n_checks++;
        if (PCAdd_pc !== 16'd1000) begin n_fail++; $display("FAIL br_start: got %0d expected 1000", PCAdd_pc); end
        for (int k = 0; k < 9; k++) tick();
        n_checks++;
        if (PCAdd_pc !== 16'd1009) begin n_fail++; $display("FAIL br_pre: got %0d expected 1009", PCAdd_pc); end
        branch_taken = 1'b1; branch_target = 16'd1004;
        tick();
        branch_taken = 1'b0;
        n_checks++;
        if (PCAdd_pc !== 16'd1004 || IF_ID_valid !== 1'b0 || IF_ID_instruction !== c_nop) begin
            n_fail++; $display("FAIL br_flush: got pc=%0d v=%b instr=%h expected 1004/0/%h", PCAdd_pc, IF_ID_valid, IF_ID_instruction, c_nop);
        end
        tick();
        n_checks++;
        if (PCAdd_pc !== 16'd1005 || IF_ID_pc !== 16'd1004 || IF_ID_valid !== 1'b1) begin
            n_fail++; $display("FAIL br_refetch: got pc=%0d ifpc=%0d v=%b expected 1005/1004/1", PCAdd_pc, IF_ID_pc, IF_ID_valid);
        end
        for (int k = 0; k < 6; k++) tick();
        n_checks++;
        if (IF_ID_pc !== 16'd1010 || IF_ID_instruction !== 16'h1ABC || busy !== 1'b1) begin
            n_fail++; $display("FAIL br_halt: got ifpc=%0d instr=%h busy=%b expected 1010/1abc/1", IF_ID_pc, IF_ID_instruction, busy);
        end
        tick();
        branch_taken = 1'b1; branch_target = 16'd1008;
        tick();
        branch_taken = 1'b0;
        n_checks++;
        if (PCAdd_pc !== 16'd1008 || busy !== 1'b1 || done !== 1'b0 || IF_ID_valid !== 1'b0) begin
            n_fail++; $display("FAIL br_drain_redirect: got pc=%0d busy=%b done=%b v=%b expected 1008/1/0/0", PCAdd_pc, busy, done, IF_ID_valid);
        end
        tick();
        n_checks++;
        if (IF_ID_pc !== 16'd1008 || IF_ID_valid !== 1'b1 || PCAdd_pc !== 16'd1009) begin
            n_fail++; $display("FAIL br_drain_refetch: got ifpc=%0d v=%b pc=%0d expected 1008/1/1009", IF_ID_pc, IF_ID_valid, PCAdd_pc);
        end
        dones = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (done === 1'b1) dones++;
        end
        n_checks++;
        if (dones != 1) begin n_fail++; $display("FAIL br_done: got %0d done pulses expected 1", dones); end
    endtask

    task automatic test_bad_select();
        int dones;
        start = 1'b1; prog_sel = 4'd0;
        tick();
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || PCAdd_pc !== 16'd1010 || done !== 1'b0) begin
            n_fail++; $display("FAIL sel0: got busy=%b pc=%0d done=%b expected 0/1010/0", busy, PCAdd_pc, done);
        end
        start = 1'b1; prog_sel = 4'd11;
        tick();
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || PCAdd_pc !== 16'd1010) begin
            n_fail++; $display("FAIL sel11: got busy=%b pc=%0d expected 0/1010", busy, PCAdd_pc);
        end
        start = 1'b1; prog_sel = 4'd10;
        tick();
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || PCAdd_pc !== 16'd1000) begin
            n_fail++; $display("FAIL sel10: got busy=%b pc=%0d expected 1/1000", busy, PCAdd_pc);
        end
        dones = 0;
        for (int k = 0; k < 25; k++) begin
            tick();
            if (done === 1'b1) dones++;
        end
        n_checks++;
        if (dones != 1 || busy !== 1'b0) begin n_fail++; $display("FAIL sel10_done: got %0d pulses busy=%b expected 1/0", dones, busy); end
    endtask

    task automatic test_reset_mid();
        start = 1'b1; prog_sel = 4'd3;
        tick();
        start = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        n_checks++;
        if (PCAdd_pc !== 16'd305 || busy !== 1'b1) begin n_fail++; $display("FAIL mid_pre: got pc=%0d busy=%b expected 305/1", PCAdd_pc, busy); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if (PCAdd_pc !== 16'd0 || IF_ID_instruction !== c_nop || IF_ID_pc !== 16'd0 ||
            IF_ID_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset: got pc=%0d instr=%h ifpc=%0d v=%b busy=%b done=%b expected 0/%h/0/0/0/0",
                               PCAdd_pc, IF_ID_instruction, IF_ID_pc, IF_ID_valid, busy, done, c_nop);
        end
        start = 1'b1; prog_sel = 4'd3;
        tick();
        start = 1'b0;
        n_checks++;
        if (PCAdd_pc !== 16'd300 || busy !== 1'b1) begin n_fail++; $display("FAIL mid_restart: got pc=%0d busy=%b expected 300/1", PCAdd_pc, busy); end
        tick();
        n_checks++;
        if (IF_ID_pc !== 16'd300 || IF_ID_instruction !== tb_mem[300] || IF_ID_valid !== 1'b1) begin
            n_fail++; $display("FAIL mid_first: got ifpc=%0d instr=%h v=%b expected 300/%h/1", IF_ID_pc, IF_ID_instruction, IF_ID_valid, tb_mem[300]);
        end
    endtask

    initial begin
        for (int a = 0; a < 2048; a++) tb_mem[a] = 16'h3000 | 16'(a[11:0]);
        for (int a = 0; a < 7; a++) tb_mem[100 + a] = 16'h0A00 + 16'(a);
        tb_mem[107]  = 16'h120F;
        tb_mem[205]  = 16'h1205;
        tb_mem[1010] = 16'h1ABC;

        test_reset();
        test_add_program();
        test_stall();
        test_branch();
        test_bad_select();
        test_reset_mid();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Fetch-side neighbour of the instruction memory: owns the program counter, drives PCAdd_pc, and captures M_instruction into the IF/ID pipeline register.
- Selects one of ten resident test programs at start addresses 100..1000, handles stall and branch redirect/flush, detects program end (STA), drains the pipeline with NOPs, then signals done.

Parameters:
- PC_W, 16, program counter / address width
- MEM_DEPTH, 1024, number of instruction memory words; addresses >= MEM_DEPTH are out of range
- NOP_INSTR, 16'h6F0F, bubble instruction injected on flush/drain/reset
- HALT_OPCODE, 4'b0001, opcode (instr[15:12]) marking the last instruction of a program (STA)
- DRAIN_CYCLES, 4, NOP cycles issued after halt before done

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to run program prog_sel
- prog_sel  in  4  program number 1..10; start address = prog_sel*100
- stall  in  1  hazard stall from decode: hold PC and IF/ID
- branch_taken  in  1  branch resolved taken this cycle
- branch_target  in  PC_W  redirect address when branch_taken=1
- M_instruction  in  16  instruction read combinationally from instruction memory at PCAdd_pc
- PCAdd_pc  out  PC_W  current fetch address to instruction memory
- IF_ID_instruction  out  16  registered instruction to decode
- IF_ID_pc  out  PC_W  address of IF_ID_instruction
- IF_ID_valid  out  1  IF_ID_instruction is a real fetched instruction (0 = bubble)
- busy  out  1  program in progress (FETCH or DRAIN)
- done  out  1  one-cycle pulse at program completion

Behaviour:
- One clock; reset is synchronous and active-high. Clock port clk, reset port reset.
- Reset (any state, including mid-program): PCAdd_pc=0, IF_ID_instruction=NOP_INSTR, IF_ID_pc=0, IF_ID_valid=0, busy=0, done=0, drain counter=0, state=IDLE.
- Memory read is combinational; the instruction at PCAdd_pc is captured into IF/ID at the next edge. Fetch latency is 1 cycle.
- IDLE:
  - IF/ID holds NOP_INSTR with valid=0.
  - start=1 with prog_sel in 1..10: PC <= prog_sel*100 (10-bit multiply, zero-extended), busy <= 1, state becomes FETCH.
  - start with prog_sel of 0 or 11..15 is ignored.
- FETCH, per cycle, in priority order:
  1. branch_taken: PC <= branch_target; IF_ID <= NOP_INSTR; valid <= 0 (flush). Overrides stall.
  2. stall: PC, IF_ID_instruction, IF_ID_pc and IF_ID_valid all hold.
  3. PC >= MEM_DEPTH: IF_ID <= NOP, valid <= 0, PC holds, enter DRAIN.
  4. M_instruction[15:12]==HALT_OPCODE: IF_ID <= M_instruction, IF_ID_pc <= PC, valid <= 1, PC holds, counter <= DRAIN_CYCLES, enter DRAIN.
  5. Otherwise: IF_ID <= M_instruction, IF_ID_pc <= PC, valid <= 1, PC <= PC+1 (mod 2^PC_W).
- DRAIN:
  - IF_ID <= NOP_INSTR, valid <= 0.
  - Counter decrements each non-stalled cycle; stall freezes the counter.
  - branch_taken in DRAIN (a late-resolving BNE ahead of STA): flush as in FETCH, PC <= branch_target, return to FETCH, counter cleared.
  - Counter reaching 0: enter DONE.
- DONE: lasts one cycle with done=1 and busy=0, then returns to IDLE. PC holds its last value.
- start while busy=1 is ignored.
- branch_taken and stall are ignored in IDLE and DONE.

Test Plan:
- Reset held 2 cycles with stall=0 → all outputs at reset values; IF_ID_instruction=16'h6F0F, busy=0.
- start, prog_sel=1, memory returns ADD program words at 100..107 → PCAdd_pc steps 100..107; IF_ID_pc follows one cycle later; STA word 16'h120F captured with IF_ID_pc=107; 4 NOP cycles follow; done pulses exactly once; busy drops the same cycle.
- stall=1 for 2 cycles while PCAdd_pc=202 → PCAdd_pc stays 202 and IF/ID is frozen; the sequence resumes at 203 with no instruction lost or duplicated.
- At PCAdd_pc=1009, branch_taken=1 with branch_target=1004 → next PCAdd_pc=1004, IF_ID_valid=0 for one cycle; also exercise branch_taken in DRAIN → returns to FETCH and done is not asserted.
- start with prog_sel=0 and with prog_sel=11 → no state change and busy stays 0. Then start with prog_sel=10 → PCAdd_pc=1000.
- reset asserted mid-FETCH at PCAdd_pc=305 → next cycle all outputs at reset values, state IDLE; a new start with prog_sel=3 restarts at 300.
